// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: eight unsigned operations selected by OpCode, with a
// 16-bit result and a carry/borrow flag held in output registers.
module alu_8bit (
    input  logic        Clk,
    input  logic        RstN,
    input  logic [2:0]  OpCode,
    input  logic [7:0]  InputA,
    input  logic [7:0]  InputB,
    output logic [15:0] OutALU,
    output logic        COut
);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpMul = 3'b010,
        OpShl = 3'b011,
        OpShr = 3'b100,
        OpAnd = 3'b101,
        OpOr  = 3'b110,
        OpXor = 3'b111
    } aluOp_e;

    aluOp_e      opSel;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [15:0] nextResult;
    logic        nextCarry;

    assign opSel = aluOp_e'(OpCode);

    // Ninth bit of the difference is the borrow, set exactly when A < B.
    assign sum9  = {1'b0, InputA} + {1'b0, InputB};
    assign diff9 = {1'b0, InputA} - {1'b0, InputB};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise
        // an uncovered path would infer a latch.
        nextResult = 16'h0000;
        nextCarry  = 1'b0;
        unique case (opSel)
            OpAdd: begin
                nextResult = {7'h00, sum9};
                nextCarry  = sum9[8];
            end
            OpSub: begin
                nextResult = {8'h00, diff9[7:0]};
                nextCarry  = diff9[8];
            end
            OpMul: nextResult = {8'h00, InputA} * {8'h00, InputB};
            // Shift amounts past the field width fall out to zero naturally.
            OpShl: nextResult = {8'h00, InputA} << InputB;
            OpShr: nextResult = {8'h00, InputA >> InputB};
            OpAnd: nextResult = {8'h00, InputA & InputB};
            OpOr:  nextResult = {8'h00, InputA | InputB};
            OpXor: nextResult = {8'h00, InputA ^ InputB};
        endcase
    end

    // NOTE: reset is sampled only on the clock edge, so RstN is deliberately
    // absent from the sensitivity list.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            // NOTE: non-blocking assignments keep register updates ordered
            // like real flops regardless of block evaluation order.
            OutALU <= 16'h0000;
            COut   <= 1'b0;
        end else begin
            OutALU <= nextResult;
            COut   <= nextCarry;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: reset behaviour, every opcode, carry,
// borrow, shift extremes and a mid-stream synchronous reset.
module tb_alu_8bit;

    logic        Clk;
    logic        RstN;
    logic [2:0]  OpCode;
    logic [7:0]  InputA;
    logic [7:0]  InputB;
    logic [15:0] OutALU;
    logic        COut;

    int testCount = 0;
    int failCount = 0;

    logic [15:0] prevRes;
    logic        prevCarry;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, SHL = 3'b011,
                           SHR = 3'b100, AND = 3'b101, OR  = 3'b110, XOR = 3'b111;

    alu_8bit dut (
        .Clk    (Clk),
        .RstN   (RstN),
        .OpCode (OpCode),
        .InputA (InputA),
        .InputB (InputB),
        .OutALU (OutALU),
        .COut   (COut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Apply one operation shortly after an edge, confirm the outputs still hold
    // the previous result before the next edge, then check the new result.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] expRes, input logic expCarry);
        OpCode = op;
        InputA = a;
        InputB = b;
        #2;
        check({tag, "_hold"}, OutALU, prevRes);
        check({tag, "_hold_c"}, {15'h0, COut}, {15'h0, prevCarry});
        @(posedge Clk);
        #1;
        check(tag, OutALU, expRes);
        check({tag, "_c"}, {15'h0, COut}, {15'h0, expCarry});
        prevRes   = expRes;
        prevCarry = expCarry;
    endtask

    initial begin
        RstN   = 1'b0;
        OpCode = ADD;
        InputA = 8'd45;
        InputB = 8'd38;

        // Two reset edges with live inputs present.
        repeat (2) begin
            @(posedge Clk);
            #1;
            check("reset", OutALU, 16'h0000);
            check("reset_c", {15'h0, COut}, 16'h0000);
        end
        prevRes   = 16'h0000;
        prevCarry = 1'b0;

        RstN = 1'b1;
        runOp("release_add", ADD, 8'd45, 8'd38, 16'd83, 1'b0);

        runOp("add_45_38", ADD, 8'd45, 8'd38, 16'd83, 1'b0);
        runOp("sub_45_38", SUB, 8'd45, 8'd38, 16'd7,  1'b0);
        runOp("or_45_38",  OR,  8'd45, 8'd38, 16'd47, 1'b0);
        runOp("xor_45_38", XOR, 8'd45, 8'd38, 16'd11, 1'b0);

        runOp("mul_49_10", MUL, 8'd49, 8'd10, 16'd490,   1'b0);
        runOp("shl_49_10", SHL, 8'd49, 8'd10, 16'd50176, 1'b0);
        runOp("shr_49_10", SHR, 8'd49, 8'd10, 16'd0,     1'b0);
        runOp("and_49_10", AND, 8'd49, 8'd10, 16'd0,     1'b0);

        runOp("add_carry",  ADD, 8'd200, 8'd100, 16'h012C, 1'b1);
        runOp("sub_borrow", SUB, 8'd10,  8'd20,  16'd246,  1'b1);
        runOp("sub_equal",  SUB, 8'd20,  8'd20,  16'd0,    1'b0);
        runOp("add_max",    ADD, 8'd255, 8'd255, 16'd510,  1'b1);

        runOp("mul_max",  MUL, 8'd255, 8'd255, 16'd65025, 1'b0);
        runOp("shl_8",    SHL, 8'd255, 8'd8,   16'd65280, 1'b0);
        runOp("shl_15",   SHL, 8'd1,   8'd15,  16'h8000,  1'b0);
        runOp("shl_16",   SHL, 8'd255, 8'd16,  16'd0,     1'b0);
        runOp("shr_7",    SHR, 8'd128, 8'd7,   16'd1,     1'b0);
        runOp("shr_8",    SHR, 8'd255, 8'd8,   16'd0,     1'b0);
        runOp("and_mix",  AND, 8'hF0,  8'h3C,  16'h0030,  1'b0);
        runOp("xor_mix",  XOR, 8'hAA,  8'hFF,  16'h0055,  1'b0);
        runOp("add_zero", ADD, 8'd0,   8'd0,   16'd0,     1'b0);

        // A reset pulse between edges must not touch the outputs.
        runOp("set_carry", ADD, 8'd128, 8'd128, 16'h0100, 1'b1);
        RstN = 1'b0;
        #2;
        RstN = 1'b1;
        #1;
        check("glitch_hold", OutALU, 16'h0100);
        check("glitch_hold_c", {15'h0, COut}, 16'h0001);

        // Mid-stream reset discards the pending result.
        runOp("mid_mul", MUL, 8'd49, 8'd10, 16'd490, 1'b0);
        RstN   = 1'b0;
        OpCode = ADD;
        InputA = 8'd1;
        InputB = 8'd1;
        @(posedge Clk);
        #1;
        check("mid_reset", OutALU, 16'h0000);
        check("mid_reset_c", {15'h0, COut}, 16'h0000);
        RstN = 1'b1;
        @(posedge Clk);
        #1;
        check("after_reset", OutALU, 16'd2);
        check("after_reset_c", {15'h0, COut}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
# alu_8bit

Registered 8-bit arithmetic/logic unit with a 3-bit opcode selecting one of eight operations on two unsigned 8-bit operands. It produces a 16-bit result plus a carry/borrow flag. It is a leaf datapath block: inputs are sampled on every rising clock edge and the result is held in output registers for downstream logic.

## Interface
- No parameters; operand width is fixed at 8 bits and result width at 16 bits.
- Clk  input  1  system clock; all state updates on the rising edge.
- RstN  input  1  reset; synchronous, active-low.
- OpCode  input  3  operation select.
- InputA  input  8  operand A, unsigned.
- InputB  input  8  operand B, unsigned; also the shift amount for shift operations.
- OutALU  output  16  registered result.
- COut  output  1  registered carry (add) or borrow (sub); 0 for all other operations.

## Operation
All operands are unsigned. The result is computed combinationally from OpCode, InputA and InputB, then registered. OutALU bits above the natural result width are 0.
- 000 ADD: {COut, OutALU[7:0]} = A + B (9-bit sum); OutALU[15:8] = 0; OutALU[8] also equals the carry (OutALU = zero-extended 9-bit sum).
- 001 SUB: OutALU[7:0] = (A − B) mod 256; OutALU[15:8] = 0; COut = 1 iff A < B (borrow).
- 010 MUL: OutALU = A × B (full 16-bit product, never overflows); COut = 0.
- 011 SHL: OutALU = ({8'h00, A} << B) truncated to 16 bits; zero-fill; B ≥ 16 gives 0; COut = 0.
- 100 SHR: OutALU = {8'h00, A >> B}; zero-fill; B ≥ 8 gives 0; COut = 0.
- 101 AND: OutALU = {8'h00, A & B}; COut = 0.
- 110 OR: OutALU = {8'h00, A | B}; COut = 0.
- 111 XOR: OutALU = {8'h00, A ^ B}; COut = 0.
- All eight codes are defined; there is no illegal opcode.
- No status flags other than COut (no zero, sign or overflow outputs).

## Timing
- Reset: on a rising Clk edge with RstN = 0, OutALU = 16'h0000 and COut = 0. This has priority over the computed result.
- Reset is synchronous only. Asserting RstN between edges has no effect until the next rising edge.
- Reset mid-stream discards the pending result. The first edge with RstN = 1 afterwards loads the result of the inputs present at that edge.
- Latency: 1 cycle. Inputs stable at rising edge k appear on OutALU/COut immediately after edge k and hold until edge k+1.
- Throughput: one operation per cycle. No handshake, no stall; every non-reset edge loads a new result.
- Changing OpCode or operands between edges has no effect on outputs until the next edge.
- The combinational path (worst case: 8×8 multiply) must close within one Clk period.

## Test plan
- Reset: hold RstN = 0 for 2 edges with A = 45, B = 38, OpCode = 000 -> OutALU = 0, COut = 0. Release RstN -> the next edge gives OutALU = 83.
- A = 45, B = 38, one op per cycle:
  - ADD -> 83, COut 0
  - SUB -> 7, COut 0
  - OR -> 47
  - XOR -> 11
  - Each value appears one cycle after it is applied.
- A = 49, B = 10, one op per cycle:
  - MUL -> 490
  - SHL -> 50176
  - SHR -> 0
  - AND -> 0
  - COut = 0 throughout.
- Carry and borrow:
  - ADD 200 + 100 -> OutALU = 300 (16'h012C), COut = 1.
  - SUB 10 − 20 -> OutALU = 246, COut = 1.
  - SUB 20 − 20 -> 0, COut = 0.
- Extremes:
  - MUL 255 × 255 -> 65025.
  - SHL A = 255, B = 8 -> 65280.
  - SHL B = 16 -> 0.
  - SHR A = 128, B = 7 -> 1.
  - SHR B = 8 -> 0.
- Mid-stream reset: issue MUL 49 × 10, then assert RstN = 0 at the following edge -> outputs are 0 at that edge. Deassert with ADD 1 + 1 applied -> 2 one cycle later.
